// File: rtl/stage4_vmem_sequencer.sv
// Memory-stage vector load/store sequencer: splits unit/constant-stride vector ops into
// per-element dcache accesses and shares the single dmem port with scalar traffic.
module stage4_vmem_sequencer #(
  parameter  int unsigned MAX_VL = 32,
  localparam int unsigned VLW    = $clog2(MAX_VL) + 1
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           flush,
  input  logic           vreq_valid,
  output logic           vreq_ready,
  input  logic           vreq_store,
  input  logic [31:0]    vreq_base,
  input  logic [31:0]    vreq_stride,
  input  logic [VLW-1:0] vreq_vl,
  input  logic [1:0]     vreq_eew,
  input  logic [4:0]     vreq_vd,
  output logic [VLW-2:0] st_idx,
  input  logic [31:0]    st_data,
  input  logic           s_ren,
  input  logic           s_wen,
  input  logic [31:0]    s_addr,
  input  logic [31:0]    s_wdata,
  input  logic [3:0]     s_byte_en,
  output logic           s_busy,
  output logic [31:0]    s_rdata,
  output logic           dmem_ren,
  output logic           dmem_wen,
  output logic [31:0]    dmem_addr,
  output logic [31:0]    dmem_wdata,
  output logic [3:0]     dmem_byte_en,
  input  logic           dmem_busy,
  input  logic [31:0]    dmem_rdata,
  output logic           vwb_valid,
  output logic [4:0]     vwb_vd,
  output logic [VLW-2:0] vwb_idx,
  output logic [31:0]    vwb_data,
  output logic           vbusy,
  output logic           vdone,
  output logic           vmisalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [VLW-1:0] r_idx;
  logic [VLW-1:0] r_vl;
  logic [31:0]    r_ea;
  logic [31:0]    r_stride;
  logic [1:0]     r_eew;
  logic           r_store;
  logic [4:0]     r_vd;
  logic           r_vwb_valid;
  logic [VLW-2:0] r_vwb_idx;
  logic [31:0]    r_vwb_data;

  logic           w_idle;
  logic           w_run;
  logic           w_accept;
  logic           w_mis;
  logic           w_active;
  logic           w_elem_done;
  logic           w_last;
  logic [1:0]     w_off;
  logic [4:0]     w_shift;
  logic [3:0]     w_be;
  logic [31:0]    w_rd_shifted;
  logic [31:0]    w_ld_data;

  assign w_idle       = (r_state == S_IDLE);
  assign w_run        = (r_state == S_RUN);
  assign vreq_ready   = nRST && w_idle && !s_ren && !s_wen;
  assign w_accept     = vreq_valid && vreq_ready;
  assign w_off        = r_ea[1:0];
  assign w_shift      = {w_off, 3'b000};
  assign w_mis        = ((r_eew == 2'd1) && r_ea[0]) || ((r_eew == 2'd2) && (w_off != 2'b00));
  assign w_active     = w_run && !w_mis && !flush;
  assign w_elem_done  = w_active && !dmem_busy;
  assign w_last       = (r_idx == (r_vl - VLW'(1)));
  assign w_rd_shifted = dmem_rdata >> w_shift;

  // Lane enables and right-justified load element for the current element width
  always_comb begin
    w_be      = 4'b1111;
    w_ld_data = w_rd_shifted;
    case (r_eew)
      2'd0: begin
        w_be      = 4'b0001 << w_off;
        w_ld_data = {24'd0, w_rd_shifted[7:0]};
      end
      2'd1: begin
        w_be      = 4'b0011 << w_off;
        w_ld_data = {16'd0, w_rd_shifted[15:0]};
      end
      default: begin
        w_be      = 4'b1111;
        w_ld_data = w_rd_shifted;
      end
    endcase
  end

  // Port arbitration: scalar passes through in IDLE, vector owns the port otherwise
  always_comb begin
    dmem_ren     = 1'b0;
    dmem_wen     = 1'b0;
    dmem_addr    = 32'd0;
    dmem_wdata   = 32'd0;
    dmem_byte_en = 4'd0;
    s_busy       = 1'b0;
    s_rdata      = 32'd0;
    if (w_idle) begin
      dmem_ren     = s_ren;
      dmem_wen     = s_wen;
      dmem_addr    = s_addr;
      dmem_wdata   = s_wdata;
      dmem_byte_en = s_byte_en;
      s_busy       = dmem_busy;
      s_rdata      = dmem_rdata;
    end else begin
      s_busy = s_ren || s_wen;
      if (w_active) begin
        dmem_ren     = !r_store;
        dmem_wen     = r_store;
        dmem_addr    = {r_ea[31:2], 2'b00};
        dmem_byte_en = w_be;
        dmem_wdata   = r_store ? (st_data << w_shift) : 32'd0;
      end
    end
  end

  assign st_idx    = r_idx[VLW-2:0];
  assign vbusy     = !w_idle;
  assign vdone     = (r_state == S_DONE);
  assign vmisalign = w_run && w_mis && !flush;
  assign vwb_valid = r_vwb_valid;
  assign vwb_vd    = r_vd;
  assign vwb_idx   = r_vwb_idx;
  assign vwb_data  = r_vwb_data;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_vl        <= '0;
      r_ea        <= 32'd0;
      r_stride    <= 32'd0;
      r_eew       <= 2'd0;
      r_store     <= 1'b0;
      r_vd        <= 5'd0;
      r_vwb_valid <= 1'b0;
      r_vwb_idx   <= '0;
      r_vwb_data  <= 32'd0;
    end else begin
      r_vwb_valid <= 1'b0;
      if (flush && !w_idle) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_ea     <= vreq_base;
              r_stride <= vreq_stride;
              r_vl     <= vreq_vl;
              r_eew    <= (vreq_eew == 2'b11) ? 2'b10 : vreq_eew;
              r_store  <= vreq_store;
              r_vd     <= vreq_vd;
              r_idx    <= '0;
              r_state  <= (vreq_vl == '0) ? S_DONE : S_RUN;
            end
          end
          S_RUN: begin
            if (w_mis) begin
              r_state <= S_IDLE;
            end else if (w_elem_done) begin
              r_ea  <= r_ea + r_stride;
              r_idx <= r_idx + VLW'(1);
              if (!r_store) begin
                r_vwb_valid <= 1'b1;
                r_vwb_idx   <= r_idx[VLW-2:0];
                r_vwb_data  <= w_ld_data;
              end
              if (w_last) begin
                r_state <= S_DONE;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage4_vmem_sequencer.sv
// Directed bench for stage4_vmem_sequencer: strided loads/stores, misalign, arbitration,
// dcache stalls, flush, zero-length ops and mid-op reset.
module tb_stage4_vmem_sequencer;

  localparam int unsigned VLW = 6;

  logic           CLK = 1'b0;
  logic           nRST;
  logic           flush;
  logic           vreq_valid;
  logic           vreq_ready;
  logic           vreq_store;
  logic [31:0]    vreq_base;
  logic [31:0]    vreq_stride;
  logic [VLW-1:0] vreq_vl;
  logic [1:0]     vreq_eew;
  logic [4:0]     vreq_vd;
  logic [VLW-2:0] st_idx;
  logic [31:0]    st_data;
  logic           s_ren;
  logic           s_wen;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [3:0]     s_byte_en;
  logic           s_busy;
  logic [31:0]    s_rdata;
  logic           dmem_ren;
  logic           dmem_wen;
  logic [31:0]    dmem_addr;
  logic [31:0]    dmem_wdata;
  logic [3:0]     dmem_byte_en;
  logic           dmem_busy;
  logic [31:0]    dmem_rdata;
  logic           vwb_valid;
  logic [4:0]     vwb_vd;
  logic [VLW-2:0] vwb_idx;
  logic [31:0]    vwb_data;
  logic           vbusy;
  logic           vdone;
  logic           vmisalign;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  stage4_vmem_sequencer #(.MAX_VL(32)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .vreq_valid(vreq_valid), .vreq_ready(vreq_ready), .vreq_store(vreq_store),
    .vreq_base(vreq_base), .vreq_stride(vreq_stride), .vreq_vl(vreq_vl),
    .vreq_eew(vreq_eew), .vreq_vd(vreq_vd), .st_idx(st_idx), .st_data(st_data),
    .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_byte_en(s_byte_en), .s_busy(s_busy), .s_rdata(s_rdata),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en), .dmem_busy(dmem_busy),
    .dmem_rdata(dmem_rdata), .vwb_valid(vwb_valid), .vwb_vd(vwb_vd),
    .vwb_idx(vwb_idx), .vwb_data(vwb_data), .vbusy(vbusy), .vdone(vdone),
    .vmisalign(vmisalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer a vector op, confirm it is ready, and let it be accepted on the next edge
  task automatic start_vec(input logic st, input logic [31:0] base, input logic [31:0] stride,
                           input logic [VLW-1:0] vl, input logic [1:0] eew, input logic [4:0] vd);
    vreq_valid  = 1'b1;
    vreq_store  = st;
    vreq_base   = base;
    vreq_stride = stride;
    vreq_vl     = vl;
    vreq_eew    = eew;
    vreq_vd     = vd;
    #1;
    chk("vreq_ready_offer", 32'(vreq_ready), 32'd1);
    tick();
    vreq_valid = 1'b0;
  endtask

  logic [31:0] st_exp_addr [3];
  logic [3:0]  st_exp_be   [3];
  logic [31:0] st_exp_wd   [3];

  initial begin
    nRST = 1'b0; flush = 1'b0; vreq_valid = 1'b0; vreq_store = 1'b0;
    vreq_base = '0; vreq_stride = '0; vreq_vl = '0; vreq_eew = '0; vreq_vd = '0;
    st_data = '0; s_ren = 1'b0; s_wen = 1'b0; s_addr = '0; s_wdata = '0;
    s_byte_en = '0; dmem_busy = 1'b0; dmem_rdata = '0;
    st_exp_addr = '{32'h200, 32'h204, 32'h204};
    st_exp_be   = '{4'b0010, 4'b0001, 4'b1000};
    st_exp_wd   = '{32'h0000_C000, 32'h0000_00C1, 32'hC200_0000};

    // Reset state
    #12;
    chk("rst_vreq_ready", 32'(vreq_ready), 32'd0);
    chk("rst_vbusy", 32'(vbusy), 32'd0);
    chk("rst_vdone", 32'(vdone), 32'd0);
    chk("rst_vwb_valid", 32'(vwb_valid), 32'd0);
    chk("rst_dmem_ren", 32'(dmem_ren), 32'd0);
    nRST = 1'b1;
    tick();

    // Unit-stride 32b load, base 0x100, vl 4
    start_vec(1'b0, 32'h100, 32'd4, 6'd4, 2'd2, 5'd5);
    for (int i = 0; i < 4; i++) begin
      dmem_rdata = 32'hA000_0000 | 32'(i);
      #1;
      chk("ld32_addr", dmem_addr, 32'h100 + 32'(4 * i));
      chk("ld32_ren", 32'(dmem_ren), 32'd1);
      chk("ld32_be", 32'(dmem_byte_en), 32'hF);
      chk("ld32_vbusy", 32'(vbusy), 32'd1);
      if (i > 0) begin
        chk("ld32_wb_valid", 32'(vwb_valid), 32'd1);
        chk("ld32_wb_idx", 32'(vwb_idx), 32'(i - 1));
        chk("ld32_wb_data", vwb_data, 32'hA000_0000 | 32'(i - 1));
      end
      tick();
    end
    chk("ld32_vdone", 32'(vdone), 32'd1);
    chk("ld32_done_ren", 32'(dmem_ren), 32'd0);
    chk("ld32_wb_last_idx", 32'(vwb_idx), 32'd3);
    chk("ld32_wb_last_data", vwb_data, 32'hA000_0003);
    chk("ld32_wb_vd", 32'(vwb_vd), 32'd5);
    tick();
    chk("ld32_after_vdone", 32'(vdone), 32'd0);
    chk("ld32_after_vbusy", 32'(vbusy), 32'd0);
    chk("ld32_after_wb", 32'(vwb_valid), 32'd0);

    // Stride-3 8b store, base 0x201, vl 3
    start_vec(1'b1, 32'h201, 32'd3, 6'd3, 2'd0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      st_data = 32'hC0 + 32'(i);
      #1;
      chk("st8_st_idx", 32'(st_idx), 32'(i));
      chk("st8_wen", 32'(dmem_wen), 32'd1);
      chk("st8_ren", 32'(dmem_ren), 32'd0);
      chk("st8_addr", dmem_addr, st_exp_addr[i]);
      chk("st8_be", 32'(dmem_byte_en), 32'(st_exp_be[i]));
      chk("st8_wdata", dmem_wdata, st_exp_wd[i]);
      tick();
    end
    chk("st8_vdone", 32'(vdone), 32'd1);
    chk("st8_no_wb", 32'(vwb_valid), 32'd0);
    tick();

    // 16b load at odd address aborts with misalign
    start_vec(1'b0, 32'h103, 32'd2, 6'd2, 2'd1, 5'd1);
    #1;
    chk("mis_pulse", 32'(vmisalign), 32'd1);
    chk("mis_no_ren", 32'(dmem_ren), 32'd0);
    chk("mis_no_vdone", 32'(vdone), 32'd0);
    tick();
    chk("mis_idle", 32'(vbusy), 32'd0);
    chk("mis_pulse_end", 32'(vmisalign), 32'd0);
    chk("mis_no_vdone2", 32'(vdone), 32'd0);
    chk("mis_ready", 32'(vreq_ready), 32'd1);

    // Scalar wins a tie, vector goes next; scalar waits while vector owns port
    s_ren = 1'b1; s_addr = 32'h300; s_byte_en = 4'hF; dmem_rdata = 32'h1234_5678;
    vreq_valid = 1'b1; vreq_store = 1'b0; vreq_base = 32'h40; vreq_stride = 32'd4;
    vreq_vl = 6'd1; vreq_eew = 2'd2; vreq_vd = 5'd9;
    #1;
    chk("arb_vreq_ready", 32'(vreq_ready), 32'd0);
    chk("arb_s_ren_pass", 32'(dmem_ren), 32'd1);
    chk("arb_s_addr_pass", dmem_addr, 32'h300);
    chk("arb_s_rdata", s_rdata, 32'h1234_5678);
    chk("arb_s_busy", 32'(s_busy), 32'd0);
    tick();
    s_ren = 1'b0;
    #1;
    chk("arb_vreq_ready_free", 32'(vreq_ready), 32'd1);
    tick();
    vreq_valid = 1'b0;
    s_wen = 1'b1; s_addr = 32'h44; s_wdata = 32'h5555_AAAA; dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("arb_vec_ren", 32'(dmem_ren), 32'd1);
    chk("arb_vec_wen", 32'(dmem_wen), 32'd0);
    chk("arb_vec_addr", dmem_addr, 32'h40);
    chk("arb_s_busy_run", 32'(s_busy), 32'd1);
    tick();
    chk("arb_vdone", 32'(vdone), 32'd1);
    chk("arb_wb_data", vwb_data, 32'hCAFE_F00D);
    chk("arb_s_busy_done", 32'(s_busy), 32'd1);
    tick();
    chk("arb_s_wen_pass", 32'(dmem_wen), 32'd1);
    chk("arb_s_wr_addr", dmem_addr, 32'h44);
    chk("arb_s_busy_idle", 32'(s_busy), 32'd0);
    s_wen = 1'b0;

    // dcache busy for 3 cycles on idx1
    start_vec(1'b0, 32'h500, 32'd4, 6'd4, 2'd2, 5'd3);
    dmem_rdata = 32'hB0;
    #1;
    chk("stall_addr0", dmem_addr, 32'h500);
    tick();
    dmem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_addr_hold", dmem_addr, 32'h504);
      chk("stall_ren_hold", 32'(dmem_ren), 32'd1);
      chk("stall_wb_valid", 32'(vwb_valid), (k == 0) ? 32'd1 : 32'd0);
      tick();
    end
    dmem_busy = 1'b0; dmem_rdata = 32'hB1;
    #1;
    chk("stall_addr_rel", dmem_addr, 32'h504);
    tick();
    chk("stall_wb1_valid", 32'(vwb_valid), 32'd1);
    chk("stall_wb1_idx", 32'(vwb_idx), 32'd1);
    chk("stall_wb1_data", vwb_data, 32'hB1);
    chk("stall_addr2", dmem_addr, 32'h508);
    tick();
    tick();
    chk("stall_vdone", 32'(vdone), 32'd1);
    tick();

    // Flush during idx2 of a vl=8 store
    start_vec(1'b1, 32'h600, 32'd4, 6'd8, 2'd2, 5'd2);
    st_data = 32'h1111_0000;
    #1;
    chk("fl_wen0", 32'(dmem_wen), 32'd1);
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("fl_st_idx", 32'(st_idx), 32'd2);
    chk("fl_wen_forced", 32'(dmem_wen), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_idle", 32'(vbusy), 32'd0);
    chk("fl_no_vdone", 32'(vdone), 32'd0);
    chk("fl_no_wen", 32'(dmem_wen), 32'd0);
    s_ren = 1'b1; s_addr = 32'h900; flush = 1'b1;
    #1;
    chk("fl_idle_scalar", 32'(dmem_ren), 32'd1);
    s_ren = 1'b0; flush = 1'b0;

    // Zero-length op completes without access
    start_vec(1'b0, 32'h800, 32'd4, 6'd0, 2'd2, 5'd4);
    chk("vl0_vdone", 32'(vdone), 32'd1);
    chk("vl0_vbusy", 32'(vbusy), 32'd1);
    chk("vl0_no_ren", 32'(dmem_ren), 32'd0);
    tick();
    chk("vl0_vdone_end", 32'(vdone), 32'd0);

    // Sub-word loads right-justify the lane
    start_vec(1'b0, 32'h702, 32'd1, 6'd1, 2'd0, 5'd6);
    dmem_rdata = 32'h4433_2211;
    #1;
    chk("ld8_be", 32'(dmem_byte_en), 32'b0100);
    tick();
    chk("ld8_data", vwb_data, 32'h33);
    tick();
    start_vec(1'b0, 32'h702, 32'd2, 6'd1, 2'd1, 5'd6);
    #1;
    chk("ld16_be", 32'(dmem_byte_en), 32'b1100);
    tick();
    chk("ld16_data", vwb_data, 32'h4433);
    tick();

    // eew=11 behaves as 32b; reset mid-op returns to reset state immediately
    start_vec(1'b0, 32'h10, 32'd4, 6'd2, 2'd3, 5'd8);
    dmem_rdata = 32'h7777_7777;
    #1;
    chk("eew3_be", 32'(dmem_byte_en), 32'hF);
    chk("eew3_addr", dmem_addr, 32'h10);
    tick();
    nRST = 1'b0;
    #1;
    chk("mrst_vbusy", 32'(vbusy), 32'd0);
    chk("mrst_ren", 32'(dmem_ren), 32'd0);
    chk("mrst_wb", 32'(vwb_valid), 32'd0);
    chk("mrst_ready", 32'(vreq_ready), 32'd0);
    #3;
    nRST = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
